// File: rtl/rank_pipe_pkg.sv
// Shared definitions for the rank pipeline stages.
// Holds the default payload widths and the serial-number rank compare
// used both here and by the downstream PIFO.
package rank_pipe_pkg;

  localparam int unsigned FLOW_ID_WIDTH = 16;
  localparam int unsigned RANK_WIDTH    = 16;
  localparam int unsigned META_WIDTH    = 16;

  // a precedes b when the modular difference a-b is negative
  function automatic logic rank_lt(input logic [RANK_WIDTH-1:0] a,
                                   input logic [RANK_WIDTH-1:0] b);
    logic [RANK_WIDTH-1:0] diff;
    diff = a - b;
    return diff[RANK_WIDTH-1];
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head entry is presented on dout the cycle
// after it is written, with no read request needed.
// Ports: clk, rst_n (async, active-low), wr_en/din (write is dropped when
// full, even if a read happens in the same cycle), rd_en (ignored when
// empty), dout (zero while empty), full, empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 48,
  parameter int unsigned MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      do_wr_c;
  logic                      do_rd_c;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr_c = wr_en & ~full;
  assign do_rd_c = rd_en & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage array, no reset needed: entries are only visible via count
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd_c) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wrr_flow_table.sv
// Per-flow scheduling state: last assigned rank, buffered packet count and
// stride for every flow, plus the registered count of active flows.
// Ports: clk, rst_n; vt (current virtual time); insert port ins_en/ins_flow
// with the combinational rank ins_rank_c; remove port rem_en/rem_flow;
// stride-write port wr_en/wr_flow/wr_data; num_active_flows.
module wrr_flow_table #(
  parameter int unsigned NUM_FLOWS = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned RANK_W    = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned STRIDE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RANK_W-1:0]   vt,
  input  logic                ins_en,
  input  logic [IDX_W-1:0]    ins_flow,
  output logic [RANK_W-1:0]   ins_rank_c,
  input  logic                rem_en,
  input  logic [IDX_W-1:0]    rem_flow,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_flow,
  input  logic [STRIDE_W-1:0] wr_data,
  output logic [CNT_W-1:0]    num_active_flows
);

  logic [RANK_W-1:0]   last_rank  [NUM_FLOWS];
  logic [CNT_W-1:0]    pkt_count  [NUM_FLOWS];
  logic [STRIDE_W-1:0] stride     [NUM_FLOWS];
  logic [RANK_W-1:0]   last_nxt   [NUM_FLOWS];
  logic [CNT_W-1:0]    cnt_nxt    [NUM_FLOWS];
  logic [STRIDE_W-1:0] stride_nxt [NUM_FLOWS];
  logic [CNT_W-1:0]    active_nxt;

  // an idle flow rejoins at virtual time, a busy one continues its own chain;
  // activity is judged on the registered count so a same-cycle pop is unseen
  assign ins_rank_c = ((pkt_count[ins_flow] == '0) ? vt : last_rank[ins_flow])
                      + RANK_W'(stride[ins_flow]);

  // next-state for the table; a zero stride is never stored
  always_comb begin
    last_nxt   = last_rank;
    cnt_nxt    = pkt_count;
    stride_nxt = stride;
    active_nxt = '0;
    if (ins_en) begin
      last_nxt[ins_flow] = ins_rank_c;
      cnt_nxt[ins_flow]  = cnt_nxt[ins_flow] + CNT_W'(1);
    end
    if (rem_en) cnt_nxt[rem_flow] = cnt_nxt[rem_flow] - CNT_W'(1);
    if (wr_en && (wr_data != '0)) stride_nxt[wr_flow] = wr_data;
    for (int f = 0; f < int'(NUM_FLOWS); f++) begin
      if (cnt_nxt[f] != '0) active_nxt = active_nxt + CNT_W'(1);
    end
  end

  // table registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < int'(NUM_FLOWS); f++) begin
        last_rank[f] <= '0;
        pkt_count[f] <= '0;
        stride[f]    <= STRIDE_W'(1);
      end
      num_active_flows <= '0;
    end else begin
      last_rank        <= last_nxt;
      pkt_count        <= cnt_nxt;
      stride           <= stride_nxt;
      num_active_flows <= active_nxt;
    end
  end

endmodule

// File: rtl/wrr_rank.sv
// Weighted round-robin rank computer: tags each arriving packet with a
// start-time fair-queueing rank and buffers {rank, flow, meta} for the PIFO.
// Ports: clk, rst (async, active-low); insert/flowID_in/meta_in with
// ins_ready and the one-cycle drop_out pulse; remove with head outputs
// valid_out/rank_out/flowID_out/meta_out; stride_wr_en/stride_wr_flow/
// stride_wr_data; num_active_flows.
module wrr_rank #(
  parameter int unsigned FLOW_ID_WIDTH = rank_pipe_pkg::FLOW_ID_WIDTH,
  parameter int unsigned MAX_NUM_FLOWS = 4,
  parameter int unsigned RANK_WIDTH    = rank_pipe_pkg::RANK_WIDTH,
  parameter int unsigned META_WIDTH    = rank_pipe_pkg::META_WIDTH,
  parameter int unsigned L2_MAX_DEPTH  = 4,
  parameter int unsigned STRIDE_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     insert,
  input  logic [FLOW_ID_WIDTH-1:0] flowID_in,
  input  logic [META_WIDTH-1:0]    meta_in,
  output logic                     ins_ready,
  output logic                     drop_out,
  input  logic                     remove,
  output logic                     valid_out,
  output logic [RANK_WIDTH-1:0]    rank_out,
  output logic [FLOW_ID_WIDTH-1:0] flowID_out,
  output logic [META_WIDTH-1:0]    meta_out,
  input  logic                     stride_wr_en,
  input  logic [FLOW_ID_WIDTH-1:0] stride_wr_flow,
  input  logic [STRIDE_WIDTH-1:0]  stride_wr_data,
  output logic [L2_MAX_DEPTH:0]    num_active_flows
);

  localparam int unsigned FLOW_IDX_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1;
  localparam int unsigned ENTRY_W    = RANK_WIDTH + FLOW_ID_WIDTH + META_WIDTH;

  logic [RANK_WIDTH-1:0] vt_r;
  logic [RANK_WIDTH-1:0] ins_rank_c;
  logic [ENTRY_W-1:0]    fifo_din;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  ins_acc_c;
  logic                  rem_acc_c;
  logic                  wr_acc_c;

  assign ins_ready = ~fifo_full;
  assign valid_out = ~fifo_empty;
  // full is judged on the registered occupancy, so a same-cycle pop never frees a slot
  assign ins_acc_c = insert & (flowID_in < FLOW_ID_WIDTH'(MAX_NUM_FLOWS)) & ~fifo_full;
  assign rem_acc_c = remove & ~fifo_empty;
  assign wr_acc_c  = stride_wr_en & (stride_wr_flow < FLOW_ID_WIDTH'(MAX_NUM_FLOWS));
  assign fifo_din  = {ins_rank_c, flowID_in, meta_in};
  assign {rank_out, flowID_out, meta_out} = fifo_dout;

  // virtual time follows the last dequeued rank; drop pulse for rejected inserts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vt_r     <= '0;
      drop_out <= 1'b0;
    end else begin
      drop_out <= insert & ~ins_acc_c;
      if (rem_acc_c) vt_r <= rank_out;
    end
  end

  wrr_flow_table #(
    .NUM_FLOWS (MAX_NUM_FLOWS),
    .IDX_W     (FLOW_IDX_W),
    .RANK_W    (RANK_WIDTH),
    .CNT_W     (L2_MAX_DEPTH + 1),
    .STRIDE_W  (STRIDE_WIDTH)
  ) u_flow_table (
    .clk              (clk),
    .rst_n            (rst),
    .vt               (vt_r),
    .ins_en           (ins_acc_c),
    .ins_flow         (flowID_in[FLOW_IDX_W-1:0]),
    .ins_rank_c       (ins_rank_c),
    .rem_en           (rem_acc_c),
    .rem_flow         (flowID_out[FLOW_IDX_W-1:0]),
    .wr_en            (wr_acc_c),
    .wr_flow          (stride_wr_flow[FLOW_IDX_W-1:0]),
    .wr_data          (stride_wr_data),
    .num_active_flows (num_active_flows)
  );

  fallthrough_small_fifo #(
    .WIDTH          (ENTRY_W),
    .MAX_DEPTH_BITS (L2_MAX_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .wr_en (ins_acc_c),
    .din   (fifo_din),
    .rd_en (rem_acc_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_wrr_rank.sv
// Bench for wrr_rank: a reference model of the flow table and virtual time
// pushes expected FIFO entries on insert; each test pops and compares.
module tb_wrr_rank;

  localparam int NF    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [15:0] rank;
    logic [15:0] flow;
    logic [15:0] meta;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        insert;
  logic [15:0] flowID_in;
  logic [15:0] meta_in;
  logic        ins_ready;
  logic        drop_out;
  logic        remove;
  logic        valid_out;
  logic [15:0] rank_out;
  logic [15:0] flowID_out;
  logic [15:0] meta_out;
  logic        stride_wr_en;
  logic [15:0] stride_wr_flow;
  logic [7:0]  stride_wr_data;
  logic [4:0]  num_active_flows;

  wrr_rank dut (
    .clk(clk), .rst(rst), .insert(insert), .flowID_in(flowID_in), .meta_in(meta_in),
    .ins_ready(ins_ready), .drop_out(drop_out), .remove(remove), .valid_out(valid_out),
    .rank_out(rank_out), .flowID_out(flowID_out), .meta_out(meta_out),
    .stride_wr_en(stride_wr_en), .stride_wr_flow(stride_wr_flow),
    .stride_wr_data(stride_wr_data), .num_active_flows(num_active_flows)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_last   [NF];
  logic [4:0]  m_cnt    [NF];
  logic [7:0]  m_stride [NF];
  logic [15:0] m_vt;
  entry_t      sb [$];
  entry_t      popped;
  logic [15:0] exp_rank;
  bit          exp_drop;

  task automatic model_reset();
    sb.delete();
    m_vt = '0;
    for (int i = 0; i < NF; i++) begin
      m_last[i] = '0; m_cnt[i] = '0; m_stride[i] = 8'd1;
    end
  endtask

  function automatic logic [4:0] model_active();
    logic [4:0] n = '0;
    for (int i = 0; i < NF; i++) if (m_cnt[i] != '0) n = n + 5'd1;
    return n;
  endfunction

  // one clock of stimulus from a falling edge to the next, model updated at the rising edge
  task automatic step(input bit ins, input logic [15:0] fid, input logic [15:0] meta, input bit rem);
    bit acc, rok;
    logic [1:0] f;
    entry_t e;
    acc = ins && (fid < 16'(NF)) && (sb.size() < DEPTH);
    rok = rem && (sb.size() != 0);
    f = fid[1:0];
    exp_rank = ((m_cnt[f] == '0) ? m_vt : m_last[f]) + 16'(m_stride[f]);
    exp_drop = ins && !acc;
    insert = ins; flowID_in = fid; meta_in = meta; remove = rem;
    @(posedge clk);
    if (rok) begin
      popped = sb.pop_front();
      m_vt = popped.rank;
      m_cnt[popped.flow[1:0]] = m_cnt[popped.flow[1:0]] - 5'd1;
    end
    if (acc) begin
      e.rank = exp_rank; e.flow = fid; e.meta = meta;
      sb.push_back(e);
      m_last[f] = exp_rank;
      m_cnt[f] = m_cnt[f] + 5'd1;
    end
    @(negedge clk);
    insert = 1'b0; remove = 1'b0;
  endtask

  task automatic set_stride(input logic [15:0] f, input logic [7:0] d);
    stride_wr_en = 1'b1; stride_wr_flow = f; stride_wr_data = d;
    @(posedge clk);
    if ((f < 16'(NF)) && (d != 8'd0)) m_stride[f[1:0]] = d;
    @(negedge clk);
    stride_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || drop_out !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b drop=%b want 0 0", valid_out, drop_out);
    end
    checks++;
    if ({rank_out, flowID_out, meta_out} !== 48'h0) begin
      errors++; $display("FAIL reset_head: got %h want 0", {rank_out, flowID_out, meta_out});
    end
    checks++;
    if (num_active_flows !== 5'd0 || ins_ready !== 1'b1) begin
      errors++; $display("FAIL reset_status: active=%0d ready=%b want 0 1", num_active_flows, ins_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_rr();
    logic [15:0] want [4];
    entry_t got;
    want = '{16'd1, 16'd1, 16'd2, 16'd2};
    step(1, 16'd0, 16'hA0, 0);
    checks++;
    if (valid_out !== 1'b1 || rank_out !== 16'd1) begin
      errors++; $display("FAIL rr_first: valid=%b rank=%0d want 1 1", valid_out, rank_out);
    end
    for (int i = 1; i < 4; i++) step(1, 16'(i % 2), 16'(16'hA0 + i), 0);
    checks++;
    if (num_active_flows !== 5'd2 || num_active_flows !== model_active()) begin
      errors++; $display("FAIL rr_active: got %0d want 2", num_active_flows);
    end
    for (int i = 0; i < 4; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped || got.rank !== want[i]) begin
        errors++; $display("FAIL rr_pop%0d: got %h want %h (rank %0d)", i, got, popped, want[i]);
      end
    end
    checks++;
    if (valid_out !== 1'b0 || num_active_flows !== 5'd0) begin
      errors++; $display("FAIL rr_empty: valid=%b active=%0d want 0 0", valid_out, num_active_flows);
    end
  endtask

  task automatic test_stride();
    logic [15:0] want [5];
    logic [15:0] flows [5];
    entry_t got;
    want  = '{16'd1, 16'd2, 16'd2, 16'd4, 16'd1};
    flows = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    do_reset();
    set_stride(16'd1, 8'd2);
    set_stride(16'd9, 8'd5);  // out-of-range flow: ignored
    set_stride(16'd2, 8'd0);  // zero stride: ignored
    for (int i = 0; i < 5; i++) step(1, flows[i], 16'(16'hB0 + i), 0);
    for (int i = 0; i < 5; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped || got.rank !== want[i]) begin
        errors++; $display("FAIL stride_pop%0d: got %h want %h (rank %0d)", i, got, popped, want[i]);
      end
    end
  endtask

  task automatic test_rejoin();
    logic [15:0] want [3];
    entry_t got;
    want = '{16'd2, 16'd4, 16'd3};
    do_reset();
    set_stride(16'd1, 8'd2);
    for (int i = 0; i < 4; i++) step(1, 16'(i / 2), 16'(16'hC0 + i), 0);
    for (int i = 0; i < 2; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped) begin
        errors++; $display("FAIL rejoin_drain%0d: got %h want %h", i, got, popped);
      end
    end
    step(1, 16'd0, 16'hC9, 0);
    checks++;
    if (num_active_flows !== 5'd2) begin
      errors++; $display("FAIL rejoin_active: got %0d want 2", num_active_flows);
    end
    for (int i = 0; i < 3; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped || got.rank !== want[i]) begin
        errors++; $display("FAIL rejoin_pop%0d: got %h want %h (rank %0d)", i, got, popped, want[i]);
      end
    end
  endtask

  task automatic test_drop();
    entry_t got;
    do_reset();
    step(1, 16'd7, 16'hD7, 0);
    checks++;
    if (drop_out !== 1'b1 || valid_out !== 1'b0 || num_active_flows !== 5'd0) begin
      errors++; $display("FAIL drop_badflow: drop=%b valid=%b active=%0d want 1 0 0", drop_out, valid_out, num_active_flows);
    end
    step(0, '0, '0, 0);
    checks++;
    if (drop_out !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: got %b want 0", drop_out);
    end
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i % 4), 16'(16'hE0 + i), 0);
    checks++;
    if (ins_ready !== 1'b0 || drop_out !== 1'b0 || num_active_flows !== 5'd4) begin
      errors++; $display("FAIL drop_full: ready=%b drop=%b active=%0d want 0 0 4", ins_ready, drop_out, num_active_flows);
    end
    step(1, 16'd0, 16'hEE, 0);
    checks++;
    if (drop_out !== exp_drop || drop_out !== 1'b1 || ins_ready !== 1'b0) begin
      errors++; $display("FAIL drop_whenfull: drop=%b ready=%b want 1 0", drop_out, ins_ready);
    end
    got = {rank_out, flowID_out, meta_out};
    step(1, 16'd1, 16'hEF, 1);
    checks++;
    if (drop_out !== 1'b1 || ins_ready !== 1'b1 || got !== popped) begin
      errors++; $display("FAIL drop_fullpop: drop=%b ready=%b head %h want 1 1 %h", drop_out, ins_ready, got, popped);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped) begin
        errors++; $display("FAIL drop_pop%0d: got %h want %h", i, got, popped);
      end
    end
    checks++;
    if (valid_out !== 1'b0 || num_active_flows !== 5'd0) begin
      errors++; $display("FAIL drop_empty: valid=%b active=%0d want 0 0", valid_out, num_active_flows);
    end
  endtask

  task automatic test_same_cycle();
    entry_t got;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'd0, 16'(16'hF0 + i), 0);
    for (int i = 0; i < 4; i++) begin
      got = {rank_out, flowID_out, meta_out};
      step(0, '0, '0, 1);
      checks++;
      if (got !== popped) begin
        errors++; $display("FAIL same_drain%0d: got %h want %h", i, got, popped);
      end
    end
    got = {rank_out, flowID_out, meta_out};
    step(1, 16'd0, 16'hF9, 1);
    checks++;
    if (got !== popped || got.rank !== 16'd5) begin
      errors++; $display("FAIL same_pop: got %h want %h (rank 5)", got, popped);
    end
    checks++;
    if (rank_out !== 16'd6 || rank_out !== sb[0].rank || num_active_flows !== 5'd1) begin
      errors++; $display("FAIL same_rank: rank=%0d active=%0d want 6 1", rank_out, num_active_flows);
    end
    got = {rank_out, flowID_out, meta_out};
    step(0, '0, '0, 1);
    checks++;
    if (got !== popped || valid_out !== 1'b0) begin
      errors++; $display("FAIL same_last: got %h valid=%b want %h 0", got, valid_out, popped);
    end
  endtask

  task automatic test_wrap_reset();
    entry_t got;
    do_reset();
    set_stride(16'd0, 8'd255);
    for (int i = 0; i < 256; i++) begin
      step(1, 16'd0, 16'(i), 0);
      step(0, '0, '0, 1);
    end
    set_stride(16'd0, 8'd254);
    step(1, 16'd0, 16'h1234, 0);
    got = {rank_out, flowID_out, meta_out};
    step(0, '0, '0, 1);
    checks++;
    if (got !== popped || got.rank !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_vt: got %h want %h (rank fffe)", got, popped);
    end
    set_stride(16'd0, 8'd3);
    step(1, 16'd0, 16'h5555, 0);
    checks++;
    if (rank_out !== 16'h0001 || rank_out !== exp_rank) begin
      errors++; $display("FAIL wrap_rank: got %h want 0001", rank_out);
    end
    step(1, 16'd0, 16'h6666, 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || num_active_flows !== 5'd0 || ins_ready !== 1'b1 || rank_out !== 16'h0) begin
      errors++; $display("FAIL midreset: valid=%b active=%0d ready=%b rank=%h want 0 0 1 0", valid_out, num_active_flows, ins_ready, rank_out);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 16'd0, 16'h7777, 0);
    checks++;
    if (valid_out !== 1'b1 || rank_out !== 16'd1 || meta_out !== 16'h7777) begin
      errors++; $display("FAIL post_reset: valid=%b rank=%0d meta=%h want 1 1 7777", valid_out, rank_out, meta_out);
    end
  endtask

  initial begin
    rst = 1'b0; insert = 1'b0; remove = 1'b0; stride_wr_en = 1'b0;
    flowID_in = '0; meta_in = '0; stride_wr_flow = '0; stride_wr_data = '0;
    model_reset();
    test_reset();
    test_rr();
    test_stride();
    test_rejoin();
    test_drop();
    test_same_cycle();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_rank.md
# wrr_rank

Weighted round-robin rank computer for the rank pipeline: assigns each arriving packet a start-time-fair-queueing rank from per-flow programmable strides and a virtual time that tracks the last dequeued rank. It buffers {rank, flowID, meta} in an internal fall-through FIFO for the downstream PIFO stage. It also tracks per-flow occupancy, so a flow that drains and returns rejoins at current virtual time rather than at its stale last rank.

## Interface
- FLOW_ID_WIDTH, 16, flow ID width
- MAX_NUM_FLOWS, 4, number of tracked flows; IDs 0..MAX_NUM_FLOWS-1 valid
- RANK_WIDTH, 16, rank width; modulo arithmetic
- META_WIDTH, 16, metadata width
- L2_MAX_DEPTH, 4, log2 FIFO depth
- STRIDE_WIDTH, 8, per-flow stride width

- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- insert  in  1  enqueue request
- flowID_in  in  FLOW_ID_WIDTH  flow of arriving packet
- meta_in  in  META_WIDTH  opaque packet metadata
- ins_ready  out  1  FIFO can accept an insert this cycle (= ~full)
- drop_out  out  1  one-cycle pulse: previous-cycle insert rejected
- remove  in  1  dequeue head; honoured only when valid_out=1
- valid_out  out  1  FIFO head valid
- rank_out  out  RANK_WIDTH  head rank
- flowID_out  out  FLOW_ID_WIDTH  head flow ID
- meta_out  out  META_WIDTH  head metadata
- stride_wr_en  in  1  stride table write strobe
- stride_wr_flow  in  FLOW_ID_WIDTH  flow to program
- stride_wr_data  in  STRIDE_WIDTH  new stride
- num_active_flows  out  L2_MAX_DEPTH+1  flows with pkt_count>0, registered

## Operation
- Per-flow state: last_rank[f] (RANK_WIDTH), pkt_count[f] (L2_MAX_DEPTH+1), stride[f] (STRIDE_WIDTH). Global: vt_r (RANK_WIDTH).
- Accepted insert (insert=1, flowID_in<MAX_NUM_FLOWS, ins_ready=1):
  - rank = (pkt_count[f]==0 ? vt_r : last_rank[f]) + stride[f], mod 2^RANK_WIDTH.
  - FIFO write of {rank, flowID_in, meta_in}; last_rank[f]<=rank; pkt_count[f]++.
- Rejected insert (flowID_in ≥ MAX_NUM_FLOWS, or ins_ready=0): no state change; drop_out=1 next cycle.
- Remove with valid_out=1: FIFO pops; vt_r<=rank_out; pkt_count[flowID_out]--. Remove with valid_out=0 is ignored.
- Activity decisions use registered pkt_count. Same-cycle insert and remove on flow f with pkt_count[f]==1: insert treats f as active and uses last_rank[f]; net count stays 1.
- Stride write: stride[f]<=data when f<MAX_NUM_FLOWS and data≠0; otherwise ignored. A same-cycle insert to f uses the old stride.
- Stride of 1 on all flows gives plain round robin.
- Wrap-around: ranks are compared downstream as serial numbers. Software must keep max_stride·2^L2_MAX_DEPTH < 2^(RANK_WIDTH-1).

## Timing
- Reset (rst=0, async): vt_r=0, every last_rank=0, pkt_count=0, stride=1, FIFO empty.
- Output values during reset: valid_out=0, drop_out=0, rank_out/flowID_out/meta_out=0 (forced to 0 whenever empty), num_active_flows=0, ins_ready=1.
- insert, remove and stride_wr_en are ignored while rst=0. Reset mid-traffic discards all buffered packets.
- Insert at cycle N: entry visible at head (valid_out=1) at N+1. No back-pressure stall; one insert per cycle sustained.
- Remove at N: next head or empty status at N+1. vt_r, pkt_count and num_active_flows update at N+1.
- Full FIFO with simultaneous insert and remove: insert rejected (ins_ready is registered-full based).

## Structure
- Shared package rank_pipe_pkg holds:
  - default width constants (FLOW_ID_WIDTH, RANK_WIDTH, META_WIDTH);
  - function rank_lt(a,b) for serial-number compare, shared with the PIFO.
- Buffering reuses fallthrough_small_fifo (WIDTH=RANK_WIDTH+FLOW_ID_WIDTH+META_WIDTH).
- Per-flow state array is one natural sub-module: wrr_flow_table. It owns last_rank, pkt_count, stride and num_active_flows, with one insert port, one remove port and one stride-write port.

## Test plan
- Reset, strides 1: insert flows 0,1,0,1 -> ranks 1,1,2,2; num_active_flows=2.
- stride[0]=1, stride[1]=2: insert 0,0,1,1 -> ranks 1,2,2,4.
- Drain flow 0 (pops ranks 1,2 → vt_r=2), then reinsert flow 0 -> rank 3 (vt_r+1), not last_rank+1; num_active_flows stays consistent.
- flowID_in=7 with MAX_NUM_FLOWS=4, and insert while full (16 entries) -> drop_out=1 next cycle; FIFO and state unchanged.
- Same-cycle insert and remove on flow 0 with pkt_count=1, last_rank=5, stride=1 -> new rank 6; pkt_count stays 1.
- Ranks near 0xFFFF (vt_r=0xFFFE, stride 3) -> rank 0x0001 wraps; assert rst mid-traffic -> valid_out=0 immediately; post-reset first rank=1.
